burst_pwm_gen: RTL

Parametrised, restartable pulse-train generator for the counter/display subsystem. It produces a rectangular waveform with programmable period and high time, grouped into bursts of N periods. Bursts are separated by programmable pause gaps and repeated R times, then the block signals completion. It generalises the fixed mod-6, 3-high/3-low divider into a runtime-configurable run/pause sequencer with start, stop and done handshakes.

---
 rtl/burst_pwm_gen_if.sv | 28 ++
 rtl/burst_pwm_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/burst_pwm_gen_if.sv
// Control/config/status bundle for burst_pwm_gen.
// The master drives start/stop and the sequence configuration; the slave returns q/busy/done.
interface burst_pwm_gen_if #(
  parameter int W  = 8,
  parameter int BW = 4,
  parameter int RW = 4
);
  logic          start;
  logic          stop;
  logic [W-1:0]  period;
  logic [W-1:0]  high;
  logic [BW-1:0] bursts;
  logic [W-1:0]  pause;
  logic [RW-1:0] reps;
  logic          q;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, period, high, bursts, pause, reps,
    input  q, busy, done
  );

  modport slave (
    input  start, stop, period, high, bursts, pause, reps,
    output q, busy, done
  );
endinterface

// File: rtl/burst_pwm_gen.sv
// Restartable burst PWM sequencer: N periods of P cycles (H high), pause L, repeated R times.
// All outputs are registered; the next-cycle values are decoded from the next-state logic.
module burst_pwm_gen #(
  parameter int W  = 8,
  parameter int BW = 4,
  parameter int RW = 4
) (
  input  logic              clk,
  input  logic              reset,
  burst_pwm_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [W-1:0]  W_ZERO  = {W{1'b0}};
  localparam logic [W-1:0]  W_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BW_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BW_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] RW_ONE  = {{(RW-1){1'b0}}, 1'b1};

  // Zero means "one", so the stored terminal count is max(v,1)-1.
  function automatic logic [W-1:0] last_w(input logic [W-1:0] v);
    if (v == W_ZERO) begin
      last_w = W_ZERO;
    end else begin
      last_w = v - W_ONE;
    end
  endfunction

  function automatic logic [RW-1:0] last_rw(input logic [RW-1:0] v);
    if (v == RW_ZERO) begin
      last_rw = RW_ZERO;
    end else begin
      last_rw = v - RW_ONE;
    end
  endfunction

  state_t        r_state;
  logic [W-1:0]  r_cnt;
  logic [BW-1:0] r_per;
  logic [RW-1:0] r_rep;
  logic [W-1:0]  r_p_last;
  logic [W-1:0]  r_h;
  logic [BW-1:0] r_n;
  logic [W-1:0]  r_l;
  logic [RW-1:0] r_r_last;
  logic          r_q;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [W-1:0]  w_cnt_nxt;
  logic [BW-1:0] w_per_nxt;
  logic [RW-1:0] w_rep_nxt;
  logic          w_done_nxt;
  logic          w_load;
  logic          w_rep_end;
  logic [W-1:0]  w_h_eff;
  logic          w_q_nxt;
  logic          w_busy_nxt;

  // State, counters and latched configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= W_ZERO;
      r_per    <= BW_ZERO;
      r_rep    <= RW_ZERO;
      r_p_last <= W_ZERO;
      r_h      <= W_ZERO;
      r_n      <= BW_ZERO;
      r_l      <= W_ZERO;
      r_r_last <= RW_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_per   <= w_per_nxt;
      r_rep   <= w_rep_nxt;
      if (w_load) begin
        r_p_last <= last_w(bus.period);
        r_h      <= bus.high;
        r_n      <= bus.bursts;
        r_l      <= bus.pause;
        r_r_last <= last_rw(bus.reps);
      end else begin
        r_p_last <= r_p_last;
        r_h      <= r_h;
        r_n      <= r_n;
        r_l      <= r_l;
        r_r_last <= r_r_last;
      end
    end
  end

  // Next-state and counter sequencing; stop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_rep_nxt   = r_rep;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_rep_end   = 1'b0;
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = W_ZERO;
      w_per_nxt   = BW_ZERO;
      w_rep_nxt   = RW_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = W_ZERO;
            w_per_nxt   = BW_ZERO;
            w_rep_nxt   = RW_ZERO;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (r_cnt == r_p_last) begin
            w_cnt_nxt = W_ZERO;
            // In continuous mode (N=0) per just wraps and is never compared.
            if ((r_n != BW_ZERO) && (r_per == (r_n - BW_ONE))) begin
              w_per_nxt = BW_ZERO;
              if (r_l != W_ZERO) begin
                w_state_nxt = ST_PAUSE;
              end else begin
                w_rep_end = 1'b1;
              end
            end else begin
              w_per_nxt = r_per + BW_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + W_ONE;
          end
        end
        ST_PAUSE: begin
          if (r_cnt == (r_l - W_ONE)) begin
            w_rep_end = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + W_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = W_ZERO;
          w_per_nxt   = BW_ZERO;
          w_rep_nxt   = RW_ZERO;
        end
      endcase
      if (w_rep_end) begin
        w_cnt_nxt = W_ZERO;
        w_per_nxt = BW_ZERO;
        if (r_rep == r_r_last) begin
          w_state_nxt = ST_IDLE;
          w_rep_nxt   = RW_ZERO;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
          w_rep_nxt   = r_rep + RW_ONE;
        end
      end else begin
        w_done_nxt = 1'b0;
      end
    end
  end

  // Output decode for the coming cycle; on a load the fresh high time is used.
  always_comb begin
    if (w_load) begin
      w_h_eff = bus.high;
    end else begin
      w_h_eff = r_h;
    end
    w_q_nxt    = (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_h_eff);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
